// File: rtl/weight_pkg.sv
// rtl/weight_pkg.sv - shared widths, FSM states and row helpers for the weight BRAM reader
package weight_pkg;

   localparam int ADDR_W    = 4;
   localparam int DATA_W    = 32;
   localparam int ELEM_W    = 8;
   localparam int CNT_W     = 5;
   localparam int ROW_ELEMS = DATA_W / ELEM_W;
   localparam int DEPTH     = 2 ** ADDR_W;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_READ,
      ST_DRAIN,
      ST_DONE
   } state_t;

   // Element k of a packed row; k=0 is column 0 in the low byte.
   function automatic logic signed [ELEM_W-1:0] row_elem(input logic [DATA_W-1:0] row,
                                                         input int unsigned k);
      return row[k*ELEM_W +: ELEM_W];
   endfunction

endpackage

// File: rtl/weight_skid_fifo.sv
// rtl/weight_skid_fifo.sv - 2-entry skid FIFO; entry 0 is always the head
module weight_skid_fifo #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic [1:0]       count
);

   logic [WIDTH-1:0] e0_q, e0_d, e1_q, e1_d;
   logic [1:0]       count_q, count_d;

   // Callers never pop when empty nor push-only when full.
   always_comb begin
      e0_d    = e0_q;
      e1_d    = e1_q;
      count_d = count_q;
      case ({push, pop})
         2'b10: begin
            if (count_q == 2'd0) e0_d = din;
            else                 e1_d = din;
            count_d = count_q + 2'd1;
         end
         2'b01: begin
            e0_d    = e1_q;
            count_d = count_q - 2'd1;
         end
         2'b11: begin
            if (count_q == 2'd2) begin
               e0_d = e1_q;
               e1_d = din;
            end else begin
               e0_d = din;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         e0_q    <= '0;
         e1_q    <= '0;
         count_q <= 2'd0;
      end else begin
         e0_q    <= e0_d;
         e1_q    <= e1_d;
         count_q <= count_d;
      end
   end

   assign dout  = e0_q;
   assign count = count_q;

endmodule

// File: rtl/weight_bram_reader.sv
// rtl/weight_bram_reader.sv - s2 read master streaming consecutive BRAM words as weight rows
module weight_bram_reader
   import weight_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [CNT_W-1:0]  num_rows,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] bram_address,
   output logic              bram_chipselect,
   output logic              bram_write,
   output logic [3:0]        bram_byteenable,
   output logic [DATA_W-1:0] bram_writedata,
   input  logic [DATA_W-1:0] bram_readdata,
   output logic              w_valid,
   input  logic              w_ready,
   output logic [DATA_W-1:0] w_data,
   output logic [ADDR_W-1:0] w_row,
   output logic              w_last
);

   localparam int               FIFO_W   = DATA_W + ADDR_W + 1;
   localparam logic [CNT_W-1:0] MAX_ROWS = CNT_W'(DEPTH);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [CNT_W-1:0]  num_q, num_d;
   logic [CNT_W-1:0]  iss_q, iss_d;
   logic [CNT_W-1:0]  rx_q, rx_d;
   logic              inflight_q, inflight_d;

   logic [FIFO_W-1:0] fifo_din, fifo_dout;
   logic [1:0]        fifo_count, pending;
   logic              fifo_pop, head_valid, head_last, issue;

   assign head_valid = (fifo_count != 2'd0);
   assign head_last  = fifo_dout[0];
   assign fifo_pop   = head_valid & w_ready;
   // Rows that will be buffered or in flight after this edge, before any new issue.
   assign pending    = fifo_count - {1'b0, fifo_pop} + {1'b0, inflight_q};
   assign fifo_din   = {bram_readdata, rx_q[ADDR_W-1:0], (rx_q == num_q - 1'b1)};

   weight_skid_fifo #(.WIDTH(FIFO_W)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (inflight_q),
      .din   (fifo_din),
      .pop   (fifo_pop),
      .dout  (fifo_dout),
      .count (fifo_count)
   );

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      num_d      = num_q;
      iss_d      = iss_q;
      rx_d       = rx_q + {{(CNT_W-1){1'b0}}, inflight_q};
      issue      = (state_q == ST_READ) && (iss_q != num_q) && (pending < 2'd2);
      inflight_d = issue;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               addr_d  = base_addr;
               num_d   = (num_rows > MAX_ROWS) ? MAX_ROWS : num_rows;
               iss_d   = '0;
               rx_d    = '0;
               state_d = (num_rows == '0) ? ST_DONE : ST_READ;
            end
         end
         ST_READ: begin
            if (issue) begin
               addr_d = addr_q + 1'b1;
               iss_d  = iss_q + 1'b1;
               if (iss_q + 1'b1 == num_q) state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (fifo_pop && head_last) state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         addr_q     <= '0;
         num_q      <= '0;
         iss_q      <= '0;
         rx_q       <= '0;
         inflight_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         num_q      <= num_d;
         iss_q      <= iss_d;
         rx_q       <= rx_d;
         inflight_q <= inflight_d;
      end
   end

   assign busy            = (state_q != ST_IDLE);
   assign done            = (state_q == ST_DONE);
   assign bram_chipselect = issue;
   assign bram_address    = issue ? addr_q : '0;
   assign bram_write      = 1'b0;
   assign bram_byteenable = 4'hF;
   assign bram_writedata  = '0;
   assign w_valid         = head_valid;
   assign w_data          = fifo_dout[FIFO_W-1 -: DATA_W];
   assign w_row           = fifo_dout[ADDR_W:1];
   assign w_last          = head_last & head_valid;

endmodule

// File: tb/tb_weight_bram_reader.sv
// tb/tb_weight_bram_reader.sv - randomized self-checking bench for weight_bram_reader
module tb_weight_bram_reader;
   import weight_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              reset, start, busy, done;
   logic [ADDR_W-1:0] base_addr, bram_address, w_row;
   logic [CNT_W-1:0]  num_rows;
   logic              bram_chipselect, bram_write, w_valid, w_ready, w_last;
   logic [3:0]        bram_byteenable;
   logic [DATA_W-1:0] bram_writedata, bram_readdata, w_data;

   weight_bram_reader dut (
      .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .num_rows(num_rows),
      .busy(busy), .done(done), .bram_address(bram_address), .bram_chipselect(bram_chipselect),
      .bram_write(bram_write), .bram_byteenable(bram_byteenable), .bram_writedata(bram_writedata),
      .bram_readdata(bram_readdata), .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
      .w_row(w_row), .w_last(w_last)
   );

   // BRAM port 2: address registered on chipselect, data visible the cycle after.
   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rd_q = '0;
   always @(posedge clk) if (bram_chipselect) rd_q <= mem[bram_address];
   assign bram_readdata = rd_q;

   int pass_cnt = 0;
   int total_cnt = 0;

   logic [DATA_W-1:0] got_data[$];
   int                got_row[$];
   bit                got_last[$];
   int                addr_seq[$];
   int                first_valid, done_cyc, last_hs_cyc, stab_err, max_out;
   logic              busy_after;

   function automatic logic rdy(input int mode, input int k);
      if (mode == 0) return 1'b1;
      if (mode == 1) return ((k % 6) == 0) || ((k % 6) == 3) || ((k % 6) == 5);
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic logic [DATA_W-1:0] model_word(input int base, input int i);
      return mem[(base + i) % DEPTH];
   endfunction

   function automatic int clamp_rows(input int n);
      return (n > DEPTH) ? DEPTH : n;
   endfunction

   task automatic do_run(input int base, input int n, input int mode, input bit mid_start);
      int                outstanding = 0;
      logic              prev_stall = 1'b0;
      logic [DATA_W-1:0] pd = '0;
      logic [ADDR_W-1:0] pr = '0;
      logic              pl = 1'b0;
      got_data.delete(); got_row.delete(); got_last.delete(); addr_seq.delete();
      first_valid = -1; done_cyc = -1; last_hs_cyc = -1; stab_err = 0; max_out = 0;
      @(negedge clk);
      base_addr = ADDR_W'(base); num_rows = CNT_W'(n); start = 1'b1; w_ready = rdy(mode, 0);
      for (int k = 1; k < 400 && done_cyc < 0; k++) begin
         @(negedge clk);
         start = mid_start && (k == 3);
         if (start) begin base_addr = 4'd8; num_rows = 5'd5; end
         w_ready = rdy(mode, k);
         #1;
         if (bram_chipselect) begin addr_seq.push_back(int'(bram_address)); outstanding++; end
         if (prev_stall && (!w_valid || w_data !== pd || w_row !== pr || w_last !== pl)) stab_err++;
         if (w_valid && first_valid < 0) first_valid = k;
         if (w_valid && w_ready) begin
            got_data.push_back(w_data); got_row.push_back(int'(w_row)); got_last.push_back(w_last);
            outstanding--; last_hs_cyc = k;
         end
         if (outstanding > max_out) max_out = outstanding;
         prev_stall = w_valid && !w_ready;
         pd = w_data; pr = w_row; pl = w_last;
         if (done) done_cyc = k;
      end
      start = 1'b0; w_ready = 1'b1;
      @(negedge clk); #1;
      busy_after = busy;
   endtask

   task automatic test_reset();
      total_cnt++;
      if ({busy, done, bram_chipselect, bram_address, bram_write, bram_writedata, w_valid, w_data, w_row, w_last} !== '0)
         $display("FAIL reset_outputs: got busy=%b done=%b cs=%b valid=%b data=%h", busy, done, bram_chipselect, w_valid, w_data);
      else pass_cnt++;
      total_cnt++;
      if (bram_byteenable !== 4'hF) $display("FAIL reset_byteenable: got %h expected f", bram_byteenable);
      else pass_cnt++;
   endtask

   task automatic test_basic();
      for (int i = 0; i < DEPTH; i++) mem[i] = 32'h0A0B0C00 + i;
      do_run(0, 4, 0, 1'b0);
      total_cnt++;
      if (first_valid !== 3) $display("FAIL basic_latency: got %0d expected 3", first_valid);
      else pass_cnt++;
      total_cnt++;
      if (got_data.size() !== 4) $display("FAIL basic_count: got %0d expected 4", got_data.size());
      else pass_cnt++;
      for (int i = 0; i < got_data.size() && i < 4; i++) begin
         total_cnt++;
         if (got_data[i] !== 32'h0A0B0C00 + i || got_row[i] !== i || got_last[i] !== (i == 3))
            $display("FAIL basic_beat%0d: got %h/%0d/%b expected %h/%0d/%b", i, got_data[i], got_row[i], got_last[i], 32'h0A0B0C00 + i, i, i == 3);
         else pass_cnt++;
      end
      total_cnt++;
      if (done_cyc !== 7 || last_hs_cyc !== 6 || busy_after !== 1'b0)
         $display("FAIL basic_done: got done@%0d last@%0d busy_after=%b expected 7/6/0", done_cyc, last_hs_cyc, busy_after);
      else pass_cnt++;
      total_cnt++;
      if (got_data.size() > 2 && row_elem(got_data[2], 3) !== 8'sh0A)
         $display("FAIL basic_elem: got %h expected 0a", row_elem(got_data[2], 3));
      else pass_cnt++;
   endtask

   task automatic test_backpressure();
      int bad = 0;
      do_run(0, 4, 1, 1'b0);
      for (int i = 0; i < 4; i++)
         if (i >= got_data.size() || got_data[i] !== model_word(0, i) || got_row[i] !== i || got_last[i] !== (i == 3)) bad++;
      total_cnt++;
      if (got_data.size() !== 4 || bad !== 0) $display("FAIL bp_beats: got %0d beats %0d bad expected 4 beats 0 bad", got_data.size(), bad);
      else pass_cnt++;
      total_cnt++;
      if (stab_err !== 0) $display("FAIL bp_stable: got %0d unstable stalls expected 0", stab_err);
      else pass_cnt++;
      total_cnt++;
      if (max_out > 2) $display("FAIL bp_credit: got %0d outstanding expected <=2", max_out);
      else pass_cnt++;
      total_cnt++;
      if (done_cyc !== last_hs_cyc + 1) $display("FAIL bp_done: got done@%0d expected %0d", done_cyc, last_hs_cyc + 1);
      else pass_cnt++;
   endtask

   task automatic test_wrap();
      int bad = 0;
      do_run(14, 4, 0, 1'b0);
      for (int i = 0; i < 4; i++)
         if (i >= addr_seq.size() || addr_seq[i] !== (14 + i) % DEPTH) bad++;
      total_cnt++;
      if (addr_seq.size() !== 4 || bad !== 0) $display("FAIL wrap_addr: got %0d issues %0d bad expected 14,15,0,1", addr_seq.size(), bad);
      else pass_cnt++;
      bad = 0;
      for (int i = 0; i < 4; i++)
         if (i >= got_data.size() || got_row[i] !== i || got_data[i] !== model_word(14, i)) bad++;
      total_cnt++;
      if (bad !== 0) $display("FAIL wrap_rows: got %0d bad beats expected 0", bad);
      else pass_cnt++;
   endtask

   task automatic test_zero();
      do_run(5, 0, 0, 1'b0);
      total_cnt++;
      if (done_cyc !== 1) $display("FAIL zero_done: got done@%0d expected 1", done_cyc);
      else pass_cnt++;
      total_cnt++;
      if (first_valid !== -1 || addr_seq.size() !== 0 || busy_after !== 1'b0)
         $display("FAIL zero_quiet: got valid@%0d issues=%0d busy_after=%b expected -1/0/0", first_valid, addr_seq.size(), busy_after);
      else pass_cnt++;
   endtask

   task automatic test_mid_start();
      int bad = 0;
      int stray = 0;
      do_run(0, 4, 0, 1'b1);
      for (int i = 0; i < 4; i++)
         if (i >= got_data.size() || got_data[i] !== model_word(0, i) || got_row[i] !== i) bad++;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk); #1;
         if (w_valid || busy || bram_chipselect) stray++;
      end
      total_cnt++;
      if (got_data.size() !== 4 || bad !== 0 || stray !== 0)
         $display("FAIL mid_start: got %0d beats %0d bad %0d stray expected 4/0/0", got_data.size(), bad, stray);
      else pass_cnt++;
   endtask

   task automatic test_reset_abort();
      int hs = 0;
      int bad = 0;
      @(negedge clk);
      base_addr = 4'd5; num_rows = 5'd6; start = 1'b1; w_ready = 1'b1;
      for (int k = 1; k < 12; k++) begin
         @(negedge clk);
         start = 1'b0;
         w_ready = (hs < 2);
         #1;
         if (w_valid && w_ready) hs++;
      end
      total_cnt++;
      if (hs !== 2 || w_valid !== 1'b1 || busy !== 1'b1)
         $display("FAIL abort_pre: got hs=%0d valid=%b busy=%b expected 2/1/1", hs, w_valid, busy);
      else pass_cnt++;
      reset = 1'b1;
      #1;
      total_cnt++;
      if ({w_valid, busy, bram_chipselect} !== 3'b000)
         $display("FAIL abort_async: got valid=%b busy=%b cs=%b expected 0/0/0", w_valid, busy, bram_chipselect);
      else pass_cnt++;
      @(negedge clk);
      reset = 1'b0;
      do_run(3, 3, 0, 1'b0);
      for (int i = 0; i < 3; i++)
         if (i >= got_data.size() || got_data[i] !== model_word(3, i) || got_row[i] !== i || got_last[i] !== (i == 2)) bad++;
      total_cnt++;
      if (got_data.size() !== 3 || bad !== 0 || first_valid !== 3)
         $display("FAIL abort_rerun: got %0d beats %0d bad valid@%0d expected 3/0/3", got_data.size(), bad, first_valid);
      else pass_cnt++;
   endtask

   task automatic test_random();
      for (int it = 0; it < 12; it++) begin
         int base = $urandom_range(0, DEPTH - 1);
         int n    = $urandom_range(1, 20);
         int exp_n = clamp_rows(n);
         int bad  = 0;
         for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
         do_run(base, n, 1 + (it % 2), 1'b0);
         for (int i = 0; i < exp_n; i++) begin
            if (i >= got_data.size() || got_data[i] !== model_word(base, i) || got_row[i] !== i || got_last[i] !== (i == exp_n - 1)) bad++;
            if (i >= addr_seq.size() || addr_seq[i] !== (base + i) % DEPTH) bad++;
         end
         total_cnt++;
         if (got_data.size() !== exp_n || addr_seq.size() !== exp_n || bad !== 0)
            $display("FAIL rand%0d_beats: got %0d beats %0d issues %0d bad expected %0d/%0d/0", it, got_data.size(), addr_seq.size(), bad, exp_n, exp_n);
         else pass_cnt++;
         total_cnt++;
         if (stab_err !== 0 || max_out > 2 || done_cyc !== last_hs_cyc + 1 || busy_after !== 1'b0)
            $display("FAIL rand%0d_flow: got stab=%0d out=%0d done@%0d last@%0d busy_after=%b", it, stab_err, max_out, done_cyc, last_hs_cyc, busy_after);
         else pass_cnt++;
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; w_ready = 1'b1; base_addr = '0; num_rows = '0;
      for (int i = 0; i < DEPTH; i++) mem[i] = 32'h0A0B0C00 + i;
      repeat (2) @(negedge clk);
      #1;
      test_reset();
      @(negedge clk);
      reset = 1'b0;
      test_basic();
      test_backpressure();
      test_wrap();
      test_zero();
      test_mid_start();
      test_reset_abort();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/weight_bram_reader.md
Name: weight_bram_reader

Overview:
- Read-side master for port 2 (s2) of the dual-port weight BRAM: 16 words x 32 bit, 4-bit address, address registered, read data unregistered.
- On a start command it streams a run of consecutive weight words out of the BRAM. It presents each word as one packed row of four signed int8 weights on a valid/ready stream feeding the systolic array weight loader.
- The Nios writes weights through s1. This block is the matching reader on s2.

Parameters:
- ADDR_W, 4, BRAM word-address width; memory depth is 2**ADDR_W.
- DATA_W, 32, BRAM word width and the width of one output row.
- ELEM_W, 8, width of one weight element. Element k occupies bits [8k+7:8k], k=0 is column 0.
- CNT_W, 5, width of num_rows; legal range 0..2**ADDR_W.

Ports:
- clk  in  1  system clock, shared with BRAM clk2.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle command; sampled only while busy=0.
- base_addr  in  ADDR_W  first BRAM word to read.
- num_rows  in  CNT_W  number of words to read.
- busy  out  1  high from accepted start until the done pulse.
- done  out  1  one-cycle pulse when the run has completed.
- bram_address  out  ADDR_W  connects to address2.
- bram_chipselect  out  1  connects to chipselect2; high only on issue cycles.
- bram_write  out  1  tied 0.
- bram_byteenable  out  4  tied 4'hF.
- bram_writedata  out  DATA_W  tied 0.
- bram_readdata  in  DATA_W  connects to readdata2; valid in the cycle after issue.
- w_valid  out  1  output row valid.
- w_ready  in  1  consumer accepts the row.
- w_data  out  DATA_W  packed row of four weights.
- w_row  out  ADDR_W  row index within the run, counting 0..num_rows-1.
- w_last  out  1  marks the final row of the run; qualified by w_valid.

Behaviour:
- Reset values: every output is 0. The FSM is in IDLE, the FIFO is empty, the in-flight flag and all counters are cleared.
- FSM states:
  - IDLE: start=1 latches base_addr and num_rows and sets busy. Goes to READ, or to DONE if num_rows=0.
  - READ: issues reads until num_rows have been issued, then goes to DRAIN.
  - DRAIN: waits until the FIFO is empty and the last beat has been accepted, then goes to DONE.
  - DONE: asserts done=1 for one cycle, clears busy, returns to IDLE.
- Issue rule: in READ, chipselect=1 and bram_address=current address when (FIFO occupancy after this cycle's pop) + inflight < 2.
  - Each issue increments the address modulo 2**ADDR_W, so reads wrap from 15 to 0.
- Capture: the cycle after an issue, bram_readdata is written into a 2-entry FIFO (skid buffer).
  - w_data, w_valid, w_row and w_last are driven from the FIFO head registers.
- Latency: with start sampled at edge E0, the read of base is issued in the cycle after E0 and w_valid rises after E2.
- Throughput: one row per cycle while w_ready=1.
- Backpressure: w_valid must stay high and w_data, w_row and w_last must stay stable until w_ready=1. No row may be dropped or duplicated. At most 2 rows are buffered plus in flight.
- A handshake occurs when w_valid & w_ready. w_last=1 exactly on row num_rows-1.
- done asserts in the cycle after the w_last handshake. For num_rows=0, done asserts in the cycle after the start edge and no beats are produced.
- start while busy=1 is ignored: no effect on the counters or the stream.
- num_rows values above 2**ADDR_W are clamped to 2**ADDR_W.
- reset at any time aborts the run immediately: the FIFO is cleared and w_valid, busy and chipselect drop asynchronously. Nothing persists from the run.

Decomposition:
- Shared package (weight_pkg): ADDR_W, DATA_W, ELEM_W, ROW_ELEMS=DATA_W/ELEM_W, the FSM state enum, and a row-element extract function.
- One sub-module, weight_skid_fifo: a 2-entry FIFO with count output, push/pop and simultaneous push/pop on a full FIFO allowed.
- The FSM, address counter and credit logic stay in the top level.

Test Plan:
- BRAM word i preloaded with 32'h0A0B0C00+i; base=0, num_rows=4, w_ready=1. Expect w_valid after E2, then 4 consecutive beats with w_data 0A0B0C00..0A0B0C03, w_row 0..3, w_last on the 4th beat, done pulse the next cycle, busy low after that.
- Same run with w_ready toggling 1,0,0,1,0,1... Expect beats in order with no loss or duplication, outputs stable while stalled, and chipselect never leaving more than 2 rows buffered plus in flight.
- base=14, num_rows=4. Expect bram_address sequence 14,15,0,1 and w_row 0..3.
- num_rows=0. Expect done in the cycle after start, no w_valid, and no chipselect.
- A second start pulsed mid-run with base=8 is ignored. Expect the original 4 beats only.
- reset asserted after 2 beats with w_ready=0. Expect w_valid, busy and chipselect to be 0 immediately. A new start after reset produces a clean run from its own base.
